relu_stream_arbiter: RTL and testbench

- Shares one ReLU lane between NUM_REQ requesters. Each requester first asks for a burst of N elements, then streams them through the lane.
- Round-robin grant at burst granularity. One registered output stage carries the results, each tagged with the requester id and a last flag.
- Sits between the producer engines (matmul/accumulator outputs) and the activation writeback path. It instantiates the existing combinational relu lane.

---
 rtl/relu_stream_arbiter_pkg.sv | 32 +++
 rtl/relu_stream_arbiter_if.sv | 29 ++
 rtl/relu_stream_arbiter_relu.sv | 9 +
 rtl/relu_stream_arbiter.sv | 146 ++++++++++++++
 tb/tb_relu_stream_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/relu_stream_arbiter_pkg.sv
// Shared types and helpers for relu_stream_arbiter (package relu_arb_pkg).
package relu_arb_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    localparam int DATA_WIDTH  = 8;
    localparam int LEN_WIDTH   = 8;
    localparam int STATS_WIDTH = 16;
    localparam int MAX_REQ     = 8;

    // First asserted index at or after ptr, wrapping within n requesters.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int unsigned        n = MAX_REQ);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                idx = (32'(ptr) + i) % n;
                if (!found && req[idx]) begin
                    pick  = 3'(idx);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/relu_stream_arbiter_if.sv
// Request / element / result bus between requesters and relu_stream_arbiter.
interface relu_stream_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = relu_arb_pkg::DATA_WIDTH,
    parameter int LEN_WIDTH  = relu_arb_pkg::LEN_WIDTH,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            in_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
    logic [NUM_REQ-1:0]            in_ready;
    logic                          out_valid;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [ID_WIDTH-1:0]           out_id;
    logic                          out_last;
    logic                          out_ready;

    modport master (
        output req_valid, req_len, in_valid, in_data, out_ready,
        input  req_ack, in_ready, out_valid, out_data, out_id, out_last
    );

    modport slave (
        input  req_valid, req_len, in_valid, in_data, out_ready,
        output req_ack, in_ready, out_valid, out_data, out_id, out_last
    );
endinterface

// File: rtl/relu_stream_arbiter_relu.sv
// Combinational ReLU lane: negative inputs clamp to zero, others pass through.
module relu_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);
    assign o_data = i_data[DATA_WIDTH-1] ? '0 : i_data;
endmodule

// File: rtl/relu_stream_arbiter.sv
// Burst-granular round-robin sharing of one ReLU lane with a registered output.
// Optional stats counters: define RELU_STREAM_ARBITER_STATS_EN.
module relu_stream_arbiter #(
    parameter int DATA_WIDTH = relu_arb_pkg::DATA_WIDTH,
    parameter int NUM_REQ    = 2,
    parameter int LEN_WIDTH  = relu_arb_pkg::LEN_WIDTH,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    relu_stream_arbiter_if.slave  bus,
    output logic                  busy
`ifdef RELU_STREAM_ARBITER_STATS_EN
    ,
    output logic [relu_arb_pkg::STATS_WIDTH-1:0] clamp_count,
    output logic [relu_arb_pkg::STATS_WIDTH-1:0] burst_count
`endif
);
    import relu_arb_pkg::*;

    state_t                r_state;
    state_t                w_next;
    logic                  r_armed;
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [ID_WIDTH-1:0]   r_gid;
    logic [LEN_WIDTH-1:0]  r_remaining;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ID_WIDTH-1:0]   r_out_id;
    logic                  r_out_last;

    logic                  w_any_req;
    logic                  w_grant;
    logic [ID_WIDTH-1:0]   w_pick;
    logic [LEN_WIDTH-1:0]  w_pick_len;
    logic                  w_lane_rdy;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_in_data_g;
    logic [DATA_WIDTH-1:0] w_relu;
    logic [NUM_REQ-1:0]    w_req_ack;
    logic [NUM_REQ-1:0]    w_in_ready;

    function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] v);
        return (v == ID_WIDTH'(NUM_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

    // r_armed holds off arbitration until the first edge after reset release.
    assign w_any_req   = |bus.req_valid;
    assign w_grant     = (r_state == IDLE) && r_armed && w_any_req;
    assign w_pick      = ID_WIDTH'(rr_pick(MAX_REQ'(bus.req_valid), 3'(r_rr_ptr), NUM_REQ));
    assign w_pick_len  = bus.req_len[w_pick*LEN_WIDTH +: LEN_WIDTH];
    assign w_lane_rdy  = !r_out_valid || bus.out_ready;
    assign w_in_data_g = bus.in_data[r_gid*DATA_WIDTH +: DATA_WIDTH];
    assign w_accept    = (r_state == STREAM) && bus.in_valid[r_gid] && w_lane_rdy;

    relu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .i_data (w_in_data_g),
        .o_data (w_relu)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant && w_pick_len != '0) w_next = STREAM;
            STREAM:  if (w_accept && r_remaining == LEN_WIDTH'(1)) w_next = DRAIN;
            DRAIN:   if (!r_out_valid || bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_req_ack  = '0;
        w_in_ready = '0;
        if (w_grant) w_req_ack[w_pick] = 1'b1;
        if (r_state == STREAM) w_in_ready[r_gid] = w_lane_rdy;
        busy = (r_state != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_armed     <= 1'b0;
            r_rr_ptr    <= '0;
            r_gid       <= '0;
            r_remaining <= '0;
        end else begin
            r_armed <= 1'b1;
            if (w_grant) begin
                r_gid       <= w_pick;
                r_remaining <= w_pick_len;
                if (w_pick_len == '0) r_rr_ptr <= wrap_inc(w_pick);
            end
            if (w_accept) r_remaining <= r_remaining - 1'b1;
            if (r_state == DRAIN && w_next == IDLE) r_rr_ptr <= wrap_inc(r_gid);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_relu;
            r_out_id    <= r_gid;
            r_out_last  <= (r_remaining == LEN_WIDTH'(1));
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef RELU_STREAM_ARBITER_STATS_EN
    logic [STATS_WIDTH-1:0] r_clamp_count;
    logic [STATS_WIDTH-1:0] r_burst_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_clamp_count <= '0;
            r_burst_count <= '0;
        end else begin
            if (w_accept && w_in_data_g[DATA_WIDTH-1] && r_clamp_count != '1)
                r_clamp_count <= r_clamp_count + 1'b1;
            if (w_grant && r_burst_count != '1)
                r_burst_count <= r_burst_count + 1'b1;
        end
    end

    assign clamp_count = r_clamp_count;
    assign burst_count = r_burst_count;
`endif

    assign bus.req_ack   = w_req_ack;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_id    = r_out_id;
    assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_relu_stream_arbiter.sv
// Directed self-checking bench for relu_stream_arbiter (2 requesters, 8-bit data).
module tb_relu_stream_arbiter;
    localparam int NR = 2;
    localparam int DW = 8;
    localparam int LW = 8;
    localparam int IW = 1;

    typedef logic [7:0] vec_t [8];

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy;
`ifdef RELU_STREAM_ARBITER_STATS_EN
    logic [15:0] clamp_count;
    logic [15:0] burst_count;
`endif

    int n_pass  = 0;
    int n_total = 0;
    vec_t v, e;

    relu_stream_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ID_WIDTH(IW)) bus ();

    relu_stream_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .LEN_WIDTH(LW), .ID_WIDTH(IW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
`ifdef RELU_STREAM_ARBITER_STATS_EN
        ,
        .clamp_count (clamp_count),
        .burst_count (burst_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Requests a burst (other requesters held per keep), then streams it and
    // checks every popped result; out_ready is low for stn cycles from st0.
    task automatic burst(input int id, input int len, input logic [1:0] keep,
                         input vec_t vals, input vec_t exps, input int st0, input int stn);
        int   idx = 0;
        int   nout = 0;
        int   it = 0;
        int   oth = 1 - id;
        logic held = 1'b0;
        logic [7:0] hd;
        logic hid, hl;
        @(negedge clock);
        bus.req_valid = keep | 2'(1 << id);
        bus.req_len[id*LW +: LW] = 8'(len);
        bus.in_valid = '0;
        bus.out_ready = 1'b1;
        #1;
        check("ack", 32'(bus.req_ack), 32'(1 << id));
        check("idle_busy", 32'(busy), 0);
        check("idle_ov", 32'(bus.out_valid), 0);
        if (len == 0) return;
        while (nout < len && it < 64) begin
            @(negedge clock);
            bus.req_valid = keep;
            bus.out_ready = !(it >= st0 && it < st0 + stn);
            bus.in_valid = '0;
            bus.in_valid[oth] = 1'b1;
            bus.in_data[oth*DW +: DW] = 8'h81;
            bus.in_valid[id] = (idx < len);
            if (idx < len) bus.in_data[id*DW +: DW] = vals[idx];
            #1;
            check("busy", 32'(busy), 1);
            check("rdy_other", 32'(bus.in_ready[oth]), 0);
            if (bus.out_valid && bus.out_ready) begin
                check("data", 32'(bus.out_data), 32'(exps[nout]));
                check("id", 32'(bus.out_id), 32'(id));
                check("last", 32'(bus.out_last), 32'(nout == len - 1));
                if (stn == 0) check("latency", 32'(it), 32'(nout + 1));
                nout++;
                held = 1'b0;
            end else if (bus.out_valid) begin
                check("rdy_stall", 32'(bus.in_ready[id]), 0);
                if (held) begin
                    check("hold_data", 32'(bus.out_data), 32'(hd));
                    check("hold_id", 32'(bus.out_id), 32'(hid));
                    check("hold_last", 32'(bus.out_last), 32'(hl));
                end
                hd = bus.out_data; hid = bus.out_id; hl = bus.out_last;
                held = 1'b1;
            end
            if (bus.in_valid[id] && bus.in_ready[id]) idx++;
            it++;
        end
        if (nout != len) check("timeout", 32'(nout), 32'(len));
    endtask

    initial begin
        bus.req_valid = 2'b01;
        bus.req_len   = {8'd0, 8'd3};
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_ov", 32'(bus.out_valid), 0);
        check("rst_data", 32'(bus.out_data), 0);
        check("rst_id", 32'(bus.out_id), 0);
        check("rst_last", 32'(bus.out_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rdy", 32'(bus.in_ready), 0);
        check("rst_ack", 32'(bus.req_ack), 0);
        @(negedge clock);
        reset = 1'b1;
        bus.req_valid = '0;

        // Single burst: 5, -3, 127
        v = '{8'd5, 8'hFD, 8'd127, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        e = '{8'd5, 8'd0, 8'd127, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        burst(0, 3, 2'b00, v, e, 0, 0);

        // Zero length from req1 (pointer was 1), then both requesting: pointer must now favour 0.
        @(negedge clock);
        bus.req_valid = 2'b10;
        bus.req_len = {8'd0, 8'd0};
        #1;
        check("z_ack1", 32'(bus.req_ack), 32'h2);
        check("z_busy1", 32'(busy), 0);
        @(negedge clock);
        bus.req_valid = 2'b11;
        bus.req_len = {8'd2, 8'd0};
        #1;
        check("z_ptr", 32'(bus.req_ack), 32'h1);
        check("z_ov", 32'(bus.out_valid), 0);
        check("z_busy2", 32'(busy), 0);
        v = '{8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        e = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        burst(1, 2, 2'b00, v, e, 0, 0);
`ifdef RELU_STREAM_ARBITER_STATS_EN
        check("clamp_count", 32'(clamp_count), 2);
        check("burst_count", 32'(burst_count), 4);
`endif

        // Round-robin with both requesters re-requesting immediately
        v = '{8'd10, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        e = '{8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        burst(0, 2, 2'b10, v, e, 0, 0);
        v = '{8'hF9, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        e = '{8'd0, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        burst(1, 2, 2'b01, v, e, 0, 0);
        v = '{8'd33, 8'h9C, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        e = '{8'd33, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        burst(0, 2, 2'b10, v, e, 0, 0);
        v = '{8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        e = '{8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        burst(1, 2, 2'b00, v, e, 0, 0);

        // Backpressure: out_ready low for 3 cycles mid-burst
        v = '{8'd1, 8'hFE, 8'd3, 8'hFC, 8'd0, 8'd0, 8'd0, 8'd0};
        e = '{8'd1, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        burst(0, 4, 2'b00, v, e, 2, 3);
        @(negedge clock);
        bus.in_valid = '0;
        #1;
        check("bp_no_extra", 32'(bus.out_valid), 0);
        check("bp_idle", 32'(busy), 0);

        // Reset after 2 of 5 elements
        @(negedge clock);
        bus.req_valid = 2'b01;
        bus.req_len = {8'd0, 8'd5};
        #1;
        check("mr_ack", 32'(bus.req_ack), 32'h1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            bus.req_valid = '0;
            bus.in_valid = 2'b01;
            bus.in_data[7:0] = 8'hF0;
            #1;
            check("mr_rdy", 32'(bus.in_ready), 32'h1);
        end
        @(negedge clock);
        reset = 1'b0;
        bus.req_valid = 2'b01;
        #1;
        check("mr_ov", 32'(bus.out_valid), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_rdy0", 32'(bus.in_ready), 0);
        check("mr_ack0", 32'(bus.req_ack), 0);
        @(negedge clock);
        reset = 1'b1;
        bus.req_valid = '0;
        bus.in_valid = '0;
        v = '{8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        e = '{8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        burst(0, 1, 2'b00, v, e, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
